// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch slice.
package fetch_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        DRAIN = 2'd2
    } fetch_state_t;

    localparam int INST_BYTES = 4;
    localparam logic [63:0] DEFAULT_RESET_PC = 64'h0;

endpackage

// File: rtl/fetch_fifo.sv
// Decode queue: registered head, one cycle push-to-visible, flush beats push/pop.
// The producer reserves a slot before pushing, so push into a full queue is simply dropped.
module fetch_fifo #(
    parameter int FIFO_DEPTH = 4,
    parameter int WIDTH      = 96
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          push,
    input  logic [WIDTH-1:0]              push_data,
    input  logic                          pop,
    input  logic                          flush,
    output logic [$clog2(FIFO_DEPTH):0]   count,
    output logic [WIDTH-1:0]              head
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(FIFO_DEPTH);

    logic [WIDTH-1:0] mem [FIFO_DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && (count != FULL_COUNT);
    assign do_pop  = pop && (count != '0);

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage is deliberately left unreset; the head is qualified by count downstream.
    always_ff @(posedge clock) begin
        if (do_push && !flush && !reset) begin
            mem[wr_ptr] <= push_data;
        end
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/fetch_unit.sv
// Single-outstanding instruction fetcher feeding a decode queue; queue entries visible one cycle after the response.
// Stops requesting while the queue has no free slot; redirects flush the queue and squash the in-flight response.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int ADDR_WIDTH = 64,
    parameter int INST_WIDTH = 32,
    parameter int FIFO_DEPTH = 4,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC = ADDR_WIDTH'(DEFAULT_RESET_PC)
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  redirect_valid,
    input  logic [ADDR_WIDTH-1:0] redirect_pc,
    output logic                  icache_read_enable,
    output logic [ADDR_WIDTH-1:0] icache_address,
    input  logic [INST_WIDTH-1:0] icache_data,
    input  logic                  icache_send_enable,
    output logic                  dec_valid,
    output logic [INST_WIDTH-1:0] dec_inst,
    output logic [ADDR_WIDTH-1:0] dec_pc,
    input  logic                  dec_ready
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int EW = ADDR_WIDTH + INST_WIDTH;
    localparam logic [CW-1:0]         DEPTH_COUNT = CW'(FIFO_DEPTH);
    localparam logic [ADDR_WIDTH-1:0] PC_STEP     = ADDR_WIDTH'(INST_BYTES);

    fetch_state_t          state;
    fetch_state_t          next_state;
    logic [ADDR_WIDTH-1:0] pc;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic                  kill;

    logic                  start_req;
    logic                  take_resp;
    logic                  drain_done;
    logic                  push;
    logic                  pop;
    logic [CW-1:0]         count;
    logic [EW-1:0]         head;

    always_ff @(posedge clock) begin
        if (reset) begin
            state              <= IDLE;
            icache_read_enable <= 1'b0;
        end else begin
            state              <= next_state;
            icache_read_enable <= (next_state == REQ);
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (!redirect_valid && (count < DEPTH_COUNT)) begin
                    next_state = REQ;
                end
            end
            REQ: begin
                if (icache_send_enable) begin
                    next_state = DRAIN;
                end
            end
            DRAIN: begin
                if (!icache_send_enable) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        start_req  = 1'b0;
        take_resp  = 1'b0;
        drain_done = 1'b0;
        case (state)
            IDLE:    start_req  = !redirect_valid && (count < DEPTH_COUNT);
            REQ:     take_resp  = icache_send_enable;
            DRAIN:   drain_done = !icache_send_enable;
            default: start_req  = 1'b0;
        endcase
    end

    // A redirect in the response cycle squashes that response even before kill is set.
    assign push = take_resp && !kill && !redirect_valid;
    assign pop  = dec_valid && dec_ready;

    always_ff @(posedge clock) begin
        if (reset) begin
            pc       <= RESET_PC;
            req_addr <= RESET_PC;
            kill     <= 1'b0;
        end else begin
            if (start_req) begin
                req_addr <= pc;
            end

            if (redirect_valid) begin
                pc <= {redirect_pc[ADDR_WIDTH-1:2], 2'b00};
            end else if (push) begin
                pc <= req_addr + PC_STEP;
            end

            // Once the handshake has closed there is nothing left to squash.
            if (drain_done) begin
                kill <= 1'b0;
            end else if (redirect_valid && (state != IDLE)) begin
                kill <= 1'b1;
            end
        end
    end

    assign icache_address = req_addr;

    fetch_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .WIDTH      (EW)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (push),
        .push_data ({icache_data, req_addr}),
        .pop       (pop),
        .flush     (redirect_valid),
        .count     (count),
        .head      (head)
    );

    assign dec_valid = (count != '0);
    assign dec_inst  = dec_valid ? head[EW-1:ADDR_WIDTH] : '0;
    assign dec_pc    = dec_valid ? head[ADDR_WIDTH-1:0]  : '0;

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter ADDR_WIDTH, default 64, shall set the PC and address width.
REQ-002 Parameter INST_WIDTH, default 32, shall set the instruction width.
REQ-003 Parameter FIFO_DEPTH, default 4 (power of two, at least 2), shall set the decode-queue depth.
REQ-004 Parameter RESET_PC, default 64'h0, shall set the PC loaded at reset.
REQ-005 Signal clock, input, 1 bit: clock; all state shall update on its rising edge.
REQ-006 Signal reset, input, 1 bit: reset, synchronous, active-high.
REQ-007 Signal redirect_valid, input, 1 bit: branch or exception redirect strobe.
REQ-008 Signal redirect_pc, input, ADDR_WIDTH bits: redirect target.
REQ-009 Signal icache_read_enable, output, 1 bit: instruction-cache read request.
REQ-010 Signal icache_address, output, ADDR_WIDTH bits: request address.
REQ-011 Signal icache_data, input, INST_WIDTH bits: cache data, valid while icache_send_enable=1.
REQ-012 Signal icache_send_enable, input, 1 bit: cache data-ready level.
REQ-013 Signal dec_valid, output, 1 bit: queue head valid to decode.
REQ-014 Signal dec_inst, output, INST_WIDTH bits: head instruction.
REQ-015 Signal dec_pc, output, ADDR_WIDTH bits: head instruction PC.
REQ-016 Signal dec_ready, input, 1 bit: decode accepts the head.

Function
REQ-017 The FSM shall have three states:
- IDLE: no request.
- REQ: icache_read_enable=1.
- DRAIN: icache_read_enable=0, waiting for icache_send_enable=0.
REQ-018 IDLE shall go to REQ when count < FIFO_DEPTH and redirect_valid=0; on that edge it shall latch req_addr<=pc.
REQ-019 REQ shall stay in REQ while icache_send_enable=0, and shall go to DRAIN on the first cycle icache_send_enable=1.
REQ-020 DRAIN shall go to IDLE on the first cycle icache_send_enable=0.
REQ-021 icache_read_enable shall be registered and equal 1 only in REQ.
REQ-022 icache_address shall equal req_addr, held stable throughout REQ and DRAIN.
REQ-023 When icache_send_enable=1 in REQ and kill=0, the unit shall push {icache_data, req_addr} into the queue and set pc<=req_addr+4.
REQ-024 PC addition shall wrap modulo 2^ADDR_WIDTH.
REQ-025 Only one cache request shall be outstanding; space is reserved at IDLE->REQ, so a push never meets a full queue.
REQ-026 Queue latency: an entry pushed in cycle N shall be visible on dec_valid/dec_inst/dec_pc in cycle N+1; no bypass.
REQ-027 dec_valid shall equal (count != 0); the head shall pop when dec_valid && dec_ready.
REQ-028 A simultaneous push and pop shall leave count unchanged and preserve order.
REQ-029 On redirect_valid=1 the unit shall:
- set pc<=redirect_pc with bits [1:0] forced to 0;
- flush the queue (count<=0), with flush winning over a same-cycle pop or push;
- in REQ or DRAIN, set kill<=1.
REQ-030 A redirect in REQ shall not drop icache_read_enable early; the response shall complete its handshake and be discarded.
REQ-031 A redirect arriving in the same cycle as icache_send_enable=1 shall discard that response and leave pc=redirect_pc.
REQ-032 kill shall clear on DRAIN->IDLE.
REQ-033 A redirect in IDLE shall block the IDLE->REQ transition in that cycle only.
REQ-034 Back-to-back redirects shall take the last one; each shall re-flush the queue.
REQ-035 While the queue is full, the FSM shall hold in IDLE with icache_read_enable=0.

Reset
REQ-036 While reset=1, the unit shall set state=IDLE, pc=RESET_PC, req_addr=RESET_PC, count=0, read and write pointers=0, and kill=0.
REQ-037 Output reset values shall be icache_read_enable=0, icache_address=RESET_PC, dec_valid=0, dec_inst=0, dec_pc=0.
REQ-038 Reset mid-request shall abandon the request; a stale icache_send_enable=1 after reset shall be ignored until the FSM is in REQ.
REQ-039 Queue storage contents need not be reset.

Structure
REQ-040 Package fetch_pkg shall hold the state enum fetch_state_t (IDLE, REQ, DRAIN), the INST_BYTES=4 constant and the RESET_PC default.
REQ-041 The queue shall be a sub-module fetch_fifo (parameters FIFO_DEPTH and width ADDR_WIDTH+INST_WIDTH, with push, pop, flush, count, head).
REQ-042 fetch_unit shall contain the FSM, the PC, req_addr and kill.

Verification
REQ-043 Basic fetch: after reset, with the cache model returning send_enable 3 cycles after read_enable, the bench shall see:
- address 0x0 requested, then 0x4, then 0x8;
- dec_pc=0x0, 0x4, 0x8 in order;
- dec_inst matching the model memory.
REQ-044 Backpressure: with dec_ready=0, exactly 4 requests shall issue, then icache_read_enable shall stay 0; after one pop, exactly one new request shall issue at pc=0x10.
REQ-045 Redirect in flight: redirect_pc=0x1003 while in REQ at 0x8 shall:
- hold icache_address at 0x8 until DRAIN completes;
- push nothing for the 0x8 response;
- make the next request address 0x1000;
- end the flush with dec_valid=0.
REQ-046 Same-cycle collision: redirect_valid and send_enable together shall push nothing and make the next request address equal the redirect target.
REQ-047 Wrap: redirect_pc=64'hFFFF_FFFF_FFFF_FFFC shall give a next fetch at 64'h0 after the first response.
REQ-048 Reset mid-operation: reset asserted during REQ, with send_enable=1 arriving after reset release, shall give no push, dec_valid=0, and a first new request at RESET_PC.
